// File: rtl/vga_clock_pkg.sv
// vga_clock_pkg: shared FSM state type and button index constants for the VGA clock
package vga_clock_pkg;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, HOLD, REPEAT, RELEASE} state_t;
  localparam int BTN_HRS = 0;
  localparam int BTN_MIN = 1;
  localparam int BTN_SEC = 2;
endpackage

// File: rtl/btn_sync.sv
// btn_sync: W-bit, STAGES-deep synchroniser chain with async active-low reset
module btn_sync #(
  parameter int STAGES = 2,
  parameter int W      = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES*W-1:0] sr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr <= '0;
    else sr <= {sr[(STAGES-1)*W-1:0], d};
  assign q = sr[STAGES*W-1 -: W];
endmodule

// File: rtl/time_adjust_ctrl.sv
// time_adjust_ctrl: debounced, auto-repeating, priority-serviced time-adjust buttons to one-cycle increment strobes
module time_adjust_ctrl
  import vga_clock_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_RATE     = 6,
  parameter int CNT_W           = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic adj_hrs,
  input  logic adj_min,
  input  logic adj_sec,
  output logic inc_hrs,
  output logic inc_min,
  output logic inc_sec,
  output logic repeating
);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc, tgt;
  logic [2:0] btn, sel, sel_d, inc, inc_d;
  logic sel_btn, hit;
  btn_sync #(.STAGES(SYNC_STAGES), .W(3)) u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .d({adj_sec, adj_min, adj_hrs}),
    .q(btn)
  );
  assign sel_btn = |(btn & sel);
  assign cnt_inc = cnt + 1'b1;
  assign tgt = (state == HOLD) ? CNT_W'(REPEAT_DELAY) :
               (state == REPEAT) ? CNT_W'(REPEAT_RATE) : CNT_W'(DEBOUNCE_FRAMES);
  assign hit = frame_tick && (cnt_inc >= tgt);
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel;
    inc_d   = '0;
    case (state)
      IDLE: if (|btn) begin
        sel_d   = btn[BTN_HRS] ? 3'(1 << BTN_HRS) : btn[BTN_MIN] ? 3'(1 << BTN_MIN) : 3'(1 << BTN_SEC);
        cnt_d   = '0;
        state_d = DEBOUNCE;
      end
      DEBOUNCE, HOLD, REPEAT: if (!sel_btn) begin
        cnt_d   = '0;
        state_d = (state == DEBOUNCE) ? IDLE : RELEASE;
      end else if (hit) begin
        cnt_d   = '0;
        inc_d   = sel;
        state_d = (state == DEBOUNCE) ? HOLD : REPEAT;
      end else if (frame_tick) cnt_d = cnt_inc;
      RELEASE: if (|btn) cnt_d = '0;
      else if (hit) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else if (frame_tick) cnt_d = cnt_inc;
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      inc   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sel   <= sel_d;
      inc   <= inc_d;
    end
  assign inc_hrs   = inc[BTN_HRS];
  assign inc_min   = inc[BTN_MIN];
  assign inc_sec   = inc[BTN_SEC];
  assign repeating = (state == REPEAT);
endmodule

// File: tb/tb_time_adjust_ctrl.sv
// tb_time_adjust_ctrl: directed self-checking bench for time_adjust_ctrl
module tb_time_adjust_ctrl;
  logic clk = 0, reset_n = 0, adj_hrs = 0, adj_min = 0, adj_sec = 0;
  logic [3:0] fc = '0;
  logic frame_tick, inc_hrs, inc_min, inc_sec, repeating;
  int checks = 0, passed = 0, ft = 0, n_hrs = 0, n_min = 0, n_sec = 0;
  int bad_lat = 0, bad_ex = 0, rep_first = -1;
  int sframe[$];
  logic prev_any = 0, last_t = 0;
  always #5 clk = ~clk;
  always @(posedge clk) fc <= fc + 1'b1;
  assign frame_tick = (fc == 4'd15);
  time_adjust_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_tick(frame_tick),
    .adj_hrs(adj_hrs),
    .adj_min(adj_min),
    .adj_sec(adj_sec),
    .inc_hrs(inc_hrs),
    .inc_min(inc_min),
    .inc_sec(inc_sec),
    .repeating(repeating)
  );
  task automatic step();
    logic t, any, multi;
    t = frame_tick;
    @(posedge clk);
    #1;
    last_t = t;
    if (t) ft++;
    any   = inc_hrs | inc_min | inc_sec;
    multi = (inc_hrs & inc_min) | (inc_hrs & inc_sec) | (inc_min & inc_sec);
    if (any) begin
      sframe.push_back(ft);
      if (!t) bad_lat++;
    end
    if (multi || (prev_any && any)) bad_ex++;
    n_hrs += int'(inc_hrs);
    n_min += int'(inc_min);
    n_sec += int'(inc_sec);
    if (repeating && rep_first < 0) rep_first = ft;
    prev_any = any;
  endtask
  task automatic clr();
    ft = 0; n_hrs = 0; n_min = 0; n_sec = 0; rep_first = -1;
    sframe.delete();
  endtask
  task automatic align();
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_t && n < 40);
  endtask
  task automatic run_to(input int f);
    int n = 0;
    while (ft < f && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (ft < f) $display("FAIL run_to: reached frame %0d, required %0d", ft, f);
    else passed++;
  endtask
  function automatic int last_frame();
    return sframe.size() > 0 ? sframe[sframe.size()-1] : -1;
  endfunction
  task automatic test_reset();
    adj_hrs = 1;
    repeat (3) step();
    checks++;
    if ({inc_hrs, inc_min, inc_sec, repeating} !== 4'b0)
      $display("FAIL reset_outputs: got %b want 0000", {inc_hrs, inc_min, inc_sec, repeating});
    else passed++;
    adj_hrs = 0;
    reset_n = 1;
    repeat (5) step();
    checks++;
    if ({inc_hrs, inc_min, inc_sec, repeating} !== 4'b0)
      $display("FAIL idle_outputs: got %b want 0000", {inc_hrs, inc_min, inc_sec, repeating});
    else passed++;
  endtask
  task automatic test_single_press();
    align(); clr();
    adj_min = 1;
    run_to(10);
    adj_min = 0;
    run_to(15);
    checks++;
    if (n_min !== 1) $display("FAIL min_count: got %0d want 1", n_min); else passed++;
    checks++;
    if (n_hrs + n_sec !== 0) $display("FAIL min_others: got %0d want 0", n_hrs + n_sec); else passed++;
    checks++;
    if (last_frame() !== 3) $display("FAIL min_frame: got %0d want 3", last_frame()); else passed++;
    checks++;
    if (rep_first !== -1) $display("FAIL min_repeating: got frame %0d want never", rep_first); else passed++;
  endtask
  task automatic test_auto_repeat();
    int exp_f[6] = '{3, 33, 39, 45, 51, 57};
    align(); clr();
    adj_sec = 1;
    run_to(60);
    checks++;
    if (sframe.size() !== 6) $display("FAIL rep_count: got %0d want 6", sframe.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ((i < sframe.size() ? sframe[i] : -1) !== exp_f[i])
        $display("FAIL rep_frame%0d: got %0d want %0d", i, (i < sframe.size() ? sframe[i] : -1), exp_f[i]);
      else passed++;
    end
    checks++;
    if (rep_first !== 33) $display("FAIL rep_start: got %0d want 33", rep_first); else passed++;
    checks++;
    if (n_sec !== 6) $display("FAIL rep_sec_count: got %0d want 6", n_sec); else passed++;
    adj_sec = 0;
    run_to(62);
    checks++;
    if (repeating !== 1'b0) $display("FAIL rep_after_release: got %b want 0", repeating); else passed++;
    run_to(65);
  endtask
  task automatic test_priority();
    align(); clr();
    adj_sec = 1;
    adj_hrs = 1;
    run_to(5);
    adj_hrs = 0;
    run_to(10);
    checks++;
    if (n_hrs !== 1) $display("FAIL prio_hrs: got %0d want 1", n_hrs); else passed++;
    checks++;
    if (n_sec !== 0) $display("FAIL prio_sec_ignored: got %0d want 0", n_sec); else passed++;
    adj_sec = 0;
    run_to(13);
    adj_sec = 1;
    run_to(17);
    checks++;
    if (n_sec !== 1 || last_frame() !== 16)
      $display("FAIL prio_sec_after_release: got count %0d frame %0d want count 1 frame 16", n_sec, last_frame());
    else passed++;
    adj_sec = 0;
    run_to(21);
  endtask
  task automatic test_glitch_bounce();
    align(); clr();
    adj_hrs = 1;
    run_to(2);
    adj_hrs = 0;
    run_to(4);
    checks++;
    if (n_hrs !== 0) $display("FAIL glitch_hrs: got %0d want 0", n_hrs); else passed++;
    adj_min = 1;
    run_to(7);
    checks++;
    if (n_min !== 1 || last_frame() !== 7)
      $display("FAIL glitch_idle_min: got count %0d frame %0d want count 1 frame 7", n_min, last_frame());
    else passed++;
    adj_min = 0;
    run_to(9);
    adj_min = 1;
    repeat (4) step();
    adj_min = 0;
    run_to(11);
    adj_min = 1;
    run_to(16);
    checks++;
    if (n_min !== 1) $display("FAIL bounce_restart: got %0d want 1", n_min); else passed++;
    adj_min = 0;
    run_to(20);
  endtask
  task automatic test_release_on_tick();
    int n = 0;
    align(); clr();
    adj_sec = 1;
    run_to(32);
    checks++;
    if (n_sec !== 1) $display("FAIL hold_pre: got %0d want 1", n_sec); else passed++;
    while (fc != 4'd13 && n < 20) begin
      step();
      n++;
    end
    adj_sec = 0;
    run_to(33);
    checks++;
    if (n_sec !== 1 || repeating !== 1'b0)
      $display("FAIL release_wins: got count %0d repeating %b want count 1 repeating 0", n_sec, repeating);
    else passed++;
    run_to(34);
    adj_min = 1;
    run_to(38);
    checks++;
    if (n_min !== 0) $display("FAIL release_state: got %0d want 0", n_min); else passed++;
    adj_min = 0;
    run_to(42);
  endtask
  task automatic test_reset_in_repeat();
    align(); clr();
    adj_hrs = 1;
    run_to(35);
    checks++;
    if (repeating !== 1'b1) $display("FAIL repeat_before_reset: got %b want 1", repeating); else passed++;
    reset_n = 0;
    #2;
    checks++;
    if ({inc_hrs, inc_min, inc_sec, repeating} !== 4'b0)
      $display("FAIL async_reset: got %b want 0000", {inc_hrs, inc_min, inc_sec, repeating});
    else passed++;
    repeat (3) step();
    align();
    reset_n = 1;
    clr();
    run_to(4);
    checks++;
    if (n_hrs !== 1 || last_frame() !== 3)
      $display("FAIL redebounce: got count %0d frame %0d want count 1 frame 3", n_hrs, last_frame());
    else passed++;
    adj_hrs = 0;
    run_to(8);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_priority();
    test_glitch_bounce();
    test_release_on_tick();
    test_reset_in_repeat();
    checks++;
    if (bad_lat !== 0) $display("FAIL strobe_latency: got %0d late strobes want 0", bad_lat); else passed++;
    checks++;
    if (bad_ex !== 0) $display("FAIL strobe_exclusive: got %0d violations want 0", bad_ex); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
